// File: rtl/intt_if.sv
// Host-side bus of the inverse NTT engine: transform control plus
// coefficient write and registered read ports.
interface intt_if;
  logic               start;
  logic               wr_en;
  logic [7:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic [7:0]         rd_addr;
  logic signed [15:0] rd_data;
  logic               busy;
  logic               done;

  modport master (output start, wr_en, wr_addr, wr_data, rd_addr,
                  input  rd_data, busy, done);
  modport slave  (input  start, wr_en, wr_addr, wr_data, rd_addr,
                  output rd_data, busy, done);
endinterface

// File: rtl/intt.sv
// In-place Kyber inverse NTT over a 256-entry coefficient RAM, followed by
// Montgomery scaling by 1441. One butterfly every 3 cycles, one scale every 2.
//
// state | meaning
// IDLE  | waiting for start, host owns the RAM
// RD    | fetch r[j], r[j+len] and zeta
// BF    | barrett sum / montgomery product of difference
// WR    | write both butterfly results, advance j/start/len/k
// SC_RD | fetch r[idx] for final scaling
// SC_WR | write fqmul(r[idx], 1441)
// DONE  | one-cycle completion pulse
module intt #(
  parameter int N = 256,
  parameter int Q = 3329
) (
  input  logic   clk,
  input  logic   reset,
  intt_if.slave  host
);

  localparam logic signed [31:0] QW   = 32'(Q);
  localparam logic signed [31:0] QINV = -32'sd3327;

  localparam int ZETAS [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  typedef enum logic [2:0] {IDLE, RD, BF, WR, SC_RD, SC_WR, DONE} state_t;

  state_t state_q, state_d;

  logic signed [15:0] ram [N];

  logic [7:0]         len_q;
  logic [8:0]         start_q;
  logic [7:0]         j_q;
  logic [6:0]         k_q;
  logic [7:0]         sc_q;
  logic signed [15:0] a_q, b_q, z_q, rd_q;

  logic               busy_c, done_c, we_bf, we_sc;
  logic [7:0]         j_hi;
  logic [8:0]         next_start;
  logic               grp_last, layer_last, final_bf, sc_last;
  logic signed [15:0] sum16, diff16;

  function automatic logic signed [15:0] fqmul(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    logic signed [31:0] p, m, t;
    logic signed [15:0] u;
    p = 32'(a) * 32'(b);
    m = p * QINV;
    u = m[15:0];
    t = p - 32'(u) * QW;
    return t[31:16];
  endfunction

  function automatic logic signed [15:0] barrett(input logic signed [15:0] a);
    logic signed [31:0] v, t;
    v = 32'sd20159 * 32'(a) + 32'sd33554432;
    t = v >>> 26;
    t = 32'(a) - t * QW;
    return t[15:0];
  endfunction

  assign j_hi       = j_q + len_q;
  assign next_start = start_q + {len_q, 1'b0};
  assign grp_last   = (9'(j_q) + 9'd1) == (start_q + 9'(len_q));
  assign layer_last = next_start[8];
  assign final_bf   = grp_last && layer_last && (len_q == 8'd128);
  assign sc_last    = (sc_q == 8'(N - 1));
  // int16 wrap-around before reduction, as the C reference does
  assign sum16      = a_q + b_q;
  assign diff16     = b_q - a_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host.start) state_d = RD;
      RD:      state_d = BF;
      BF:      state_d = WR;
      WR:      state_d = final_bf ? SC_RD : RD;
      SC_RD:   state_d = SC_WR;
      SC_WR:   state_d = sc_last ? DONE : SC_RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state_q != IDLE) && (state_q != DONE);
    done_c = (state_q == DONE);
    we_bf  = (state_q == WR);
    we_sc  = (state_q == SC_WR);
  end

  always_ff @(posedge clk) begin
    if (we_bf) begin
      ram[j_q]  <= a_q;
      ram[j_hi] <= b_q;
    end else if (we_sc) begin
      ram[sc_q] <= fqmul(a_q, 16'sd1441);
    end else if (host.wr_en && !busy_c) begin
      ram[host.wr_addr] <= host.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      start_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      sc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      rd_q    <= '0;
    end else begin
      // read port reads before any same-cycle write lands: old data on collision
      if (!busy_c) rd_q <= ram[host.rd_addr];
      case (state_q)
        IDLE: if (host.start) begin
          len_q   <= 8'd2;
          start_q <= '0;
          j_q     <= '0;
          k_q     <= 7'd127;
          sc_q    <= '0;
        end
        RD: begin
          a_q <= ram[j_q];
          b_q <= ram[j_hi];
          z_q <= 16'(ZETAS[k_q]);
        end
        BF: begin
          a_q <= barrett(sum16);
          b_q <= fqmul(z_q, diff16);
        end
        WR: begin
          if (grp_last) begin
            k_q <= k_q - 7'd1;
            if (layer_last) begin
              len_q   <= len_q << 1;
              start_q <= '0;
              j_q     <= '0;
            end else begin
              start_q <= next_start;
              j_q     <= next_start[7:0];
            end
          end else begin
            j_q <= j_q + 8'd1;
          end
        end
        SC_RD: a_q  <= ram[sc_q];
        SC_WR: sc_q <= sc_q + 8'd1;
        default: ;
      endcase
    end
  end

  assign host.busy    = busy_c;
  assign host.done    = done_c;
  assign host.rd_data = rd_q;

endmodule

// File: tb/tb_intt.sv
// Randomized bench for intt: a behavioural model (C-reference arithmetic on an
// int array plus a cycle-count timing model) is compared every cycle.
module tb_intt;

  logic clk = 1'b0;
  logic reset = 1'b0;

  intt_if bus ();

  intt #(.N(256), .Q(3329)) dut (
    .clk   (clk),
    .reset (reset),
    .host  (bus)
  );

  always #5 clk = ~clk;

  localparam int ZETAS [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  int checks = 0;
  int errors = 0;

  int m_mem [256];
  bit m_val [256];
  int work  [256];
  int rnd   [256];
  int rb    [256];
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_cnt  = 0;
  int exp_rd = 0;
  bit exp_rd_val = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int s16(input int x);
    shortint s;
    s = shortint'(x);
    return int'(s);
  endfunction

  function automatic int pmod(input int x);
    return ((x % 3329) + 3329) % 3329;
  endfunction

  function automatic int fqmul(input int a, input int b);
    int p, u;
    p = s16(a) * s16(b);
    u = s16(p * -3327);
    return s16((p - u * 3329) >>> 16);
  endfunction

  function automatic int barrett(input int a);
    int x, t;
    x = s16(a);
    t = (20159 * x + (1 << 25)) >>> 26;
    return s16(x - t * 3329);
  endfunction

  // C reference forward ntt on work[]
  function automatic void ref_ntt();
    int k, z, t;
    k = 1;
    for (int len = 128; len >= 2; len = len >> 1) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        z = ZETAS[k];
        k++;
        for (int j = st; j < st + len; j++) begin
          t = fqmul(z, work[j + len]);
          work[j + len] = s16(work[j] - t);
          work[j] = s16(work[j] + t);
        end
      end
    end
  endfunction

  // C reference invntt on the model RAM
  function automatic void model_invntt();
    int k, z, t;
    k = 127;
    for (int len = 2; len <= 128; len = len << 1) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        z = ZETAS[k];
        k--;
        for (int j = st; j < st + len; j++) begin
          t = m_mem[j];
          m_mem[j] = barrett(t + m_mem[j + len]);
          m_mem[j + len] = fqmul(z, s16(m_mem[j + len] - t));
        end
      end
    end
    for (int j = 0; j < 256; j++) m_mem[j] = fqmul(m_mem[j], 1441);
  endfunction

  // Timing/RAM model: a transform is 3200 cycles from the start-sampling edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      exp_rd = 0;
      exp_rd_val = 1'b1;
      for (int i = 0; i < 256; i++) m_val[i] = 1'b0;
    end else begin
      if (!m_busy) begin
        exp_rd     = m_mem[bus.rd_addr];
        exp_rd_val = m_val[bus.rd_addr];
        if (bus.wr_en) begin
          m_mem[bus.wr_addr] = int'(bus.wr_data);
          m_val[bus.wr_addr] = 1'b1;
        end
      end
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 3200) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          model_invntt();
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (bus.start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_rd_data", int'(bus.rd_data), 0);
    end else begin
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("done", int'(bus.done), int'(m_done));
      if (exp_rd_val) chk("rd_data", int'(bus.rd_data), exp_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_work();
    for (int i = 0; i < 256; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'(i);
      bus.wr_data = 16'(work[i]);
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic readback();
    for (int i = 0; i < 256; i++) begin
      bus.rd_addr = 8'(i);
      tick();
      rb[i] = int'(bus.rd_data);
    end
  endtask

  // done_edge: edge index of the done pulse, -1 on timeout, -2 when aborted by reset
  task automatic run(input bit disturb, input int rst_at, output int done_edge);
    int e;
    done_edge = -1;
    bus.start = 1'b1;
    tick();
    e = 0;
    bus.start = 1'b0;
    chk("busy_edge0", int'(bus.busy), 1);
    while (e < 4000) begin
      bus.start = disturb && (e == 99);
      bus.wr_en = disturb && (e == 199);
      if (disturb && e == 199) begin
        bus.wr_addr = 8'd5;
        bus.wr_data = 16'h7FFF;
      end
      tick();
      e++;
      if (rst_at == e) begin
        reset = 1'b1;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        tick();
        tick();
        reset = 1'b0;
        done_edge = -2;
        break;
      end
      if (bus.done) begin
        done_edge = e;
        break;
      end
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    int de, bad;
    bus.start   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    #2 reset = 1'b1;
    tick();
    tick();
    chk("rst_rd_data_lit", int'(bus.rd_data), 0);
    reset = 1'b0;
    tick();

    chk("model_barrett_q", barrett(3329), 0);
    chk("model_barrett_negq", barrett(-3329), 0);
    chk("model_fqmul_1_1", fqmul(1, 1), 169);
    chk("model_fqmul_mont", pmod(fqmul(1000, 2285)), 1000);

    // same-address write/read collision
    bus.wr_en = 1'b1; bus.wr_addr = 8'd7; bus.wr_data = 16'sd100;
    tick();
    bus.wr_data = 16'sd42; bus.rd_addr = 8'd7;
    tick();
    bus.wr_en = 1'b0;
    chk("collision_old", int'(bus.rd_data), 100);
    tick();
    chk("collision_new", int'(bus.rd_data), 42);

    // all zeros
    for (int i = 0; i < 256; i++) work[i] = 0;
    load_work();
    run(1'b0, 0, de);
    chk("done_edge_zero", de, 3200);
    readback();
    bad = 0;
    for (int i = 0; i < 256; i++) if (rb[i] != 0) bad++;
    chk("zero_outputs_nonzero", bad, 0);

    // ntt(ones) then intt must give 2285 = 2^16 mod q everywhere
    for (int i = 0; i < 256; i++) work[i] = 1;
    ref_ntt();
    load_work();
    run(1'b0, 0, de);
    chk("done_edge_ones", de, 3200);
    readback();
    bad = 0;
    for (int i = 0; i < 256; i++) if (pmod(rb[i]) != 2285) bad++;
    chk("ones_not_2285", bad, 0);

    // random coefficients, bit-exact via the compare process
    for (int i = 0; i < 256; i++) begin
      rnd[i]  = int'($urandom_range(6656)) - 3328;
      work[i] = rnd[i];
    end
    load_work();
    run(1'b0, 0, de);
    chk("done_edge_rand", de, 3200);
    readback();

    // same input with a stray start and a stray write during the transform
    for (int i = 0; i < 256; i++) work[i] = rnd[i];
    load_work();
    run(1'b1, 0, de);
    chk("done_edge_disturb", de, 3200);
    readback();

    // abort with reset at edge 1000, then reload and rerun
    load_work();
    run(1'b0, 1000, de);
    repeat (50) tick();
    for (int i = 0; i < 256; i++) work[i] = int'($urandom_range(6656)) - 3328;
    load_work();
    run(1'b0, 0, de);
    chk("done_edge_after_reset", de, 3200);
    readback();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intt.md
INTT -- requirements
Module: intt

Interface
REQ-001 The block SHALL have the parameter N, default 256, meaning polynomial length (fixed at 256; other values unsupported).
REQ-002 The block SHALL have the parameter Q, default 3329, meaning the Kyber modulus.
REQ-003 The block SHALL have the port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-005 The block SHALL have the port start, input, 1 bit, a request to begin a transform (sampled in IDLE only).
REQ-006 The block SHALL have the port wr_en, input, 1 bit, the host coefficient write strobe.
REQ-007 The block SHALL have the port wr_addr, input, 8 bits, the host write index.
REQ-008 The block SHALL have the port wr_data, input, 16 bits signed, the host write coefficient.
REQ-009 The block SHALL have the port rd_addr, input, 8 bits, the host read index.
REQ-010 The block SHALL have the port rd_data, output, 16 bits signed, the registered read coefficient.
REQ-011 The block SHALL have the port busy, output, 1 bit, high while a transform runs.
REQ-012 The block SHALL have the port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-013 The block SHALL contain a 256x16 signed coefficient RAM and a 128x16 signed zeta ROM holding the Kyber Montgomery zetas table (zetas[0]=-1044, zetas[1]=-758, zetas[127]=1628).
REQ-014 The block SHALL compute the in-place inverse NTT: k=127; for len=2,4,...,128: for start=0 step 2*len: zeta=zetas[k--]; for j=start..start+len-1: t=r[j]; r[j]=barrett(t+r[j+len]); r[j+len]=fqmul(zeta, r[j+len]-t).
REQ-015 After the 7 layers, the block SHALL replace every r[i], i=0..255 in ascending order, with fqmul(r[i], 1441).
REQ-016 The block SHALL truncate sums and differences to 16-bit two's complement before reduction (C int16 semantics).
REQ-017 fqmul(a,b) SHALL equal montgomery(a*b): p=32-bit signed product; u=low 16 bits of p*(-3327), signed; result=(p-u*Q)>>>16, 16-bit.
REQ-018 barrett(a) SHALL equal a-Q*(((20159*a)+2^25)>>>26), using a 32-bit signed intermediate and a 16-bit result.
REQ-019 The FSM SHALL have states IDLE, RD, BF, WR, SC_RD, SC_WR and DONE.
REQ-020 IDLE SHALL go to RD on start=1; otherwise it stays in IDLE.
REQ-021 Each butterfly SHALL take exactly 3 cycles (RD: read r[j] and r[j+len] and the zeta; BF: compute; WR: write both results), giving 896 butterflies and 2688 cycles.
REQ-022 Scaling SHALL take exactly 2 cycles per coefficient (SC_RD, SC_WR), giving 512 cycles.
REQ-023 After the final SC_WR the FSM SHALL enter DONE for 1 cycle and then return to IDLE.
REQ-024 Timing SHALL be measured from edge 0, the edge sampling start=1: busy=1 from edge 0, and at edge 3200 busy falls while done rises for exactly one cycle.
REQ-025 The butterfly and scaling phases SHALL have no overlap or pipelining, so no read-after-write hazard exists.
REQ-026 start SHALL be ignored while busy=1 or done=1.
REQ-027 Host writes SHALL occur only when busy=0, and wr_en SHALL be ignored while busy=1.
REQ-028 When busy=0, rd_data SHALL equal RAM[rd_addr] one cycle after rd_addr is presented.
REQ-029 rd_data SHALL hold its value while busy=1.
REQ-030 If a host write and a host read hit the same address in the same cycle, rd_data SHALL return the old value.

Reset
REQ-031 While reset=1, the FSM SHALL be IDLE, busy=0, done=0, rd_data=0 and all counters (len, start, j, k, scale index) cleared; this takes effect immediately, without waiting for clk.
REQ-032 Reset SHALL leave RAM contents unspecified and leave the ROM unaffected.
REQ-033 Reset asserted mid-transform SHALL abort the transform, with no done pulse; the next start SHALL begin a full transform from len=2, k=127.
REQ-034 After reset deasserts, start SHALL be sampled on the first rising edge.

Verification
REQ-035 The bench SHALL load all 256 coefficients with 0 and pulse start -> done at edge 3200, busy high from edge 0 to edge 3200, all outputs 0.
REQ-036 The bench SHALL load a[i]=1, run the C ntt, load the result, and run intt -> every rd_data ≡ 2285 (mod 3329).
REQ-037 The bench SHALL run random a[i] in [-3328,3328] against the C reference invntt -> bit-exact match on all 256 coefficients.
REQ-038 The bench SHALL re-pulse start at edge 100 and write wr_en=1, addr 5, data 16'h7FFF at edge 200 -> done still at edge 3200, results identical to a run without those events.
REQ-039 The bench SHALL assert reset at edge 1000 -> busy=0 and done=0 immediately, no done pulse; a reload plus start gives the correct result at edge 3200 after the new start.
REQ-040 The bench SHALL present the same wr_addr and rd_addr (7) with wr_data=42 while idle -> rd_data shows the old value, then 42 on the next read.
